// File: rtl/mbe_final_cpa_pipe.sv
// Final carry-propagate adder for the MBE radix-8 multiplier.
// Resolves the compressor tree's sum/carry rows into the binary product
// through a two-stage split adder with valid/ready flow control.
module mbe_final_cpa_pipe #(
    parameter int WIDTH = 32,
    parameter int LO_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             out_cout
);

    localparam int HI_W = WIDTH - LO_W;

    // Unsigned add of two LO_W-bit slices, returning the carry in the MSB.
    function automatic logic [LO_W:0] add_lo(input logic [LO_W-1:0] a,
                                             input logic [LO_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Unsigned add of two HI_W-bit slices plus carry-in, carry in the MSB.
    function automatic logic [HI_W:0] add_hi(input logic [HI_W-1:0] a,
                                             input logic [HI_W-1:0] b,
                                             input logic            ci);
        return {1'b0, a} + {1'b0, b} + {{HI_W{1'b0}}, ci};
    endfunction

    // Carry row realigned to product weight; its MSB falls off the top.
    logic [WIDTH-1:0] cv;
    assign cv = {carry_vec[WIDTH-2:0], 1'b0};

    // Stage 1 registers: low-half result plus the untouched high slices.
    logic [LO_W-1:0] lo_p1;
    logic            c_p1;
    logic [HI_W-1:0] hs_p1;
    logic [HI_W-1:0] hc_p1;
    logic            vld_p1;

    // Stage 2 valid; the data registers are the product/out_cout ports.
    logic            vld_p2;

    logic            adv_p1;
    logic            adv_p2;
    logic [LO_W:0]   lo_sum;
    logic [HI_W:0]   hi_sum;

    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;

    assign lo_sum = add_lo(sum_vec[LO_W-1:0], cv[LO_W-1:0]);
    assign hi_sum = add_hi(hs_p1, hc_p1, c_p1);

    // ---- stage 0 -> stage 1: low-half add, capture high slices ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            lo_p1  <= '0;
            c_p1   <= 1'b0;
            hs_p1  <= '0;
            hc_p1  <= '0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                lo_p1 <= lo_sum[LO_W-1:0];
                c_p1  <= lo_sum[LO_W];
                hs_p1 <= sum_vec[WIDTH-1:LO_W];
                hc_p1 <= cv[WIDTH-1:LO_W];
            end
        end
    end

    // ---- stage 1 -> stage 2: high-half add with split carry, hold on stall ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            product  <= '0;
            out_cout <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                product  <= {hi_sum[HI_W-1:0], lo_p1};
                out_cout <= hi_sum[HI_W];
            end
        end
    end

endmodule
